// File: rtl/result_writer_if.sv
// Product-in / RAM-port-A bundle for result_writer.
// master = result_writer side, slave = multiplier + RAM side.
interface result_writer_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3
);
    logic              prod_valid;
    logic [DATA_W-1:0] prod;
    logic              en;
    logic [0:0]        wea;
    logic [ADDR_W-1:0] addra;
    logic [DATA_W-1:0] dina;

    modport master (
        input  prod_valid,
        input  prod,
        output en,
        output wea,
        output addra,
        output dina
    );

    modport slave (
        output prod_valid,
        output prod,
        input  en,
        input  wea,
        input  addra,
        input  dina
    );
endinterface

// File: rtl/result_writer.sv
// Captures multiplier products into result RAM slots 0..DEPTH-1.
// Optional macro RESULT_CHECKSUM_EN adds an XOR checksum output.
module result_writer #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_stop,
    result_writer_if.master     bus,
`ifdef RESULT_CHECKSUM_EN
    output logic [DATA_W-1:0]   checksum,
`endif
    output logic                done,
    output logic [ADDR_W:0]     wr_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   ONE  = (ADDR_W + 1)'(1);

    state_t            state;
    logic [ADDR_W-1:0] wr_ptr;

    // Run control and registered RAM port; last slot parks the pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            wr_count  <= '0;
            done      <= 1'b0;
            bus.en    <= 1'b0;
            bus.wea   <= 1'b0;
            bus.addra <= '0;
            bus.dina  <= '0;
`ifdef RESULT_CHECKSUM_EN
            checksum  <= '0;
`endif
        end else begin
            bus.en  <= 1'b0;
            bus.wea <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start_stop) begin
                        state    <= RUN;
                        wr_ptr   <= '0;
                        wr_count <= '0;
                        done     <= 1'b0;
`ifdef RESULT_CHECKSUM_EN
                        checksum <= '0;
`endif
                    end
                end
                RUN: begin
                    if (!start_stop) begin
                        state <= IDLE;
                    end else if (bus.prod_valid) begin
                        bus.en    <= 1'b1;
                        bus.wea   <= 1'b1;
                        bus.addra <= wr_ptr;
                        bus.dina  <= bus.prod;
                        wr_count  <= wr_count + ONE;
`ifdef RESULT_CHECKSUM_EN
                        checksum  <= checksum ^ bus.prod;
`endif
                        if (wr_ptr == LAST) begin
                            state <= DONE;
                        end else begin
                            wr_ptr <= wr_ptr + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (!start_stop) begin
                        state <= IDLE;
                        done  <= 1'b0;
                    end else begin
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_result_writer.sv
// Directed bench for result_writer with a queue-based reference model.
// Checksum checks are active when RESULT_CHECKSUM_EN is defined.
module tb_result_writer;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic              start_stop;
    logic              done;
    logic [ADDR_W:0]   wr_count;
`ifdef RESULT_CHECKSUM_EN
    logic [DATA_W-1:0] checksum;
`endif

    result_writer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    result_writer #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start_stop(start_stop),
        .bus       (bus),
`ifdef RESULT_CHECKSUM_EN
        .checksum  (checksum),
`endif
        .done      (done),
        .wr_count  (wr_count)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_chk  = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    // Reference model: a run is the list of products accepted so far.
    // phase 0 = no run, 1 = collecting, 2 = list full.
    logic [DATA_W-1:0] acc[$];
    int                phase = 0;
    logic              e_wea = 0;
    logic              e_done = 0;
    logic [ADDR_W-1:0] e_addra = '0;
    logic [DATA_W-1:0] e_dina = '0;

    function automatic logic [DATA_W-1:0] xor_all();
        logic [DATA_W-1:0] x = '0;
        foreach (acc[k]) x ^= acc[k];
        return x;
    endfunction

    // Observed writes, for literal checks of addresses and data.
    logic [ADDR_W-1:0] log_a[$];
    logic [DATA_W-1:0] log_d[$];

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                phase = 0;
                acc.delete();
                e_wea = 0; e_done = 0; e_addra = '0; e_dina = '0;
            end else begin
                e_wea = 0;
                if (phase == 0) begin
                    if (start_stop) begin
                        phase = 1;
                        acc.delete();
                        e_done = 0;
                    end
                end else if (phase == 1) begin
                    if (!start_stop) begin
                        phase = 0;
                    end else if (bus.prod_valid) begin
                        e_wea   = 1;
                        e_addra = ADDR_W'(acc.size());
                        e_dina  = bus.prod;
                        acc.push_back(bus.prod);
                        if (acc.size() == DEPTH) phase = 2;
                    end
                end else begin
                    e_done = start_stop;
                    if (!start_stop) phase = 0;
                end
            end
            @(negedge clk);
            check("en", 64'(bus.en), 64'(e_wea));
            check("wea", 64'(bus.wea), 64'(e_wea));
            check("addra", 64'(bus.addra), 64'(e_addra));
            check("dina", 64'(bus.dina), 64'(e_dina));
            check("done", 64'(done), 64'(e_done));
            check("wr_count", 64'(wr_count), 64'(acc.size()));
`ifdef RESULT_CHECKSUM_EN
            check("checksum", 64'(checksum), 64'(xor_all()));
`endif
            if (bus.wea === 1'b1) begin
                log_a.push_back(bus.addra);
                log_d.push_back(bus.dina);
            end
        end
    end

    task automatic cyc(input logic s, input logic v,
                       input logic [DATA_W-1:0] d);
        start_stop     = s;
        bus.prod_valid = v;
        bus.prod       = d;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        log_a.delete();
        log_d.delete();
    endtask

    logic [DATA_W-1:0] ck_vec[6];

    initial begin
        rst = 1'b1;
        start_stop = 1'b1;
        bus.prod_valid = 1'b1;
        bus.prod = 32'h55;
        @(posedge clk);
        #1;
        cyc(1, 1, 32'h55);
        check("rst_wea", 64'(bus.wea), 64'd0);
        check("rst_cnt", 64'(wr_count), 64'd0);
        rst = 1'b0;

        // Full back-to-back run
        clear_log();
        cyc(1, 0, 0);
        for (int i = 1; i <= 6; i++) cyc(1, 1, DATA_W'(i));
        check("full_last_wea", 64'(bus.wea), 64'd1);
        check("full_last_addr", 64'(bus.addra), 64'd5);
        check("full_last_dina", 64'(bus.dina), 64'd6);
        check("full_done_early", 64'(done), 64'd0);
        cyc(1, 0, 0);
        check("full_done", 64'(done), 64'd1);
        check("full_cnt", 64'(wr_count), 64'd6);
        check("full_nwr", 64'(log_a.size()), 64'd6);
        for (int i = 0; i < 6 && i < log_a.size(); i++) begin
            check("full_addr_i", 64'(log_a[i]), 64'(i));
            check("full_data_i", 64'(log_d[i]), 64'(i + 1));
        end

        // Overflow guard in DONE
        for (int i = 0; i < 4; i++) cyc(1, 1, 32'hFFFF_FFFF);
        check("ovf_wea", 64'(bus.wea), 64'd0);
        check("ovf_addr", 64'(bus.addra), 64'd5);
        check("ovf_dina", 64'(bus.dina), 64'd6);
        cyc(0, 0, 0);
        check("rel_done", 64'(done), 64'd0);
        check("rel_cnt", 64'(wr_count), 64'd6);

        // Gapped valids
        clear_log();
        cyc(1, 0, 0);
        for (int i = 0; i < 6; i++) begin
            cyc(1, 1, 32'hDEAD_0000 + DATA_W'(i));
            cyc(1, 0, 0);
        end
        check("gap_done", 64'(done), 64'd1);
        check("gap_nwr", 64'(log_a.size()), 64'd6);
        for (int i = 0; i < 6 && i < log_a.size(); i++) begin
            check("gap_addr_i", 64'(log_a[i]), 64'(i));
            check("gap_data_i", 64'(log_d[i]), 64'(32'hDEAD_0000 + i));
        end
        cyc(0, 0, 0);
        cyc(0, 0, 0);

        // Abort after three writes
        clear_log();
        cyc(1, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 1, 32'hA0 + DATA_W'(i));
        cyc(0, 1, 32'hBAD);
        check("abort_wea", 64'(bus.wea), 64'd0);
        check("abort_cnt", 64'(wr_count), 64'd3);
        check("abort_done", 64'(done), 64'd0);
        cyc(0, 0, 0);
        check("abort_nwr", 64'(log_a.size()), 64'd3);
        cyc(1, 0, 0);
        cyc(1, 1, 32'h77);
        check("restart_addr", 64'(bus.addra), 64'd0);
        check("restart_dina", 64'(bus.dina), 64'h77);
        check("restart_cnt", 64'(wr_count), 64'd1);

        // Reset mid-run cancels the pending write
        rst = 1'b1;
        cyc(1, 1, 32'h99);
        check("midrst_wea", 64'(bus.wea), 64'd0);
        check("midrst_cnt", 64'(wr_count), 64'd0);
        rst = 1'b0;

        // Checksum run, start_stop held high through DONE
        ck_vec = '{32'h0F0F_0F0F, 32'hF0F0_F0F0, 32'h1234_5678,
                   32'h0, 32'h0, 32'h1234_5678};
        cyc(1, 0, 0);
        foreach (ck_vec[i]) cyc(1, 1, ck_vec[i]);
        for (int i = 0; i < 4; i++) cyc(1, 0, 0);
        check("held_done", 64'(done), 64'd1);
        check("held_cnt", 64'(wr_count), 64'd6);
`ifdef RESULT_CHECKSUM_EN
        check("cksum_lit", 64'(checksum), 64'hFFFF_FFFF);
`endif
        cyc(0, 0, 0);
        cyc(1, 1, 32'h5);
        cyc(1, 1, 32'h6);
        check("newrun_addr", 64'(bus.addra), 64'd0);
        check("newrun_dina", 64'(bus.dina), 64'h6);
        cyc(0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/result_writer.md
Name: result_writer

Overview:
Write-side companion to the operand-fetch controller. Captures 32-bit products from the Dadda multiplier and writes them sequentially into a result block RAM (port A: en, wea, addra, dina). Fills one result slot per valid product until DEPTH results are stored, then raises done and holds until the run is released.

Parameters:
DATA_W, 32, product / RAM data width
ADDR_W, 3, result RAM address width
DEPTH, 6, number of results per run (addresses 0..DEPTH-1); must be <= 2**ADDR_W

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
start_stop  input  1  run enable; high = accept products, low = release/abort
prod_valid  input  1  product on prod is valid this cycle
prod  input  DATA_W  multiplier product
en  output  1  RAM port enable (registered)
wea  output  [0:0]  RAM write enable (registered)
addra  output  ADDR_W  RAM write address (registered)
dina  output  DATA_W  RAM write data (registered)
done  output  1  DEPTH results written this run
wr_count  output  ADDR_W+1  results written in current run

Behaviour:
- Reset (rst sampled high): state IDLE; en=0, wea=0, addra=0, dina=0, done=0, wr_count=0, internal wr_ptr=0. rst overrides all other inputs.
- States: IDLE, RUN, DONE.
- IDLE: outputs en=0, wea=0; prod_valid ignored. start_stop=1 -> RUN next cycle with wr_ptr=0, wr_count=0, done=0.
- RUN, prod_valid=1: next edge registers dina<=prod, addra<=wr_ptr, wea<=1, en<=1; wr_ptr and wr_count increment. Latency prod_valid->wea = 1 cycle. Back-to-back valids give back-to-back writes, no bubbles.
- RUN, prod_valid=0: next edge wea<=0, en<=0; addra, dina hold last value.
- RUN, write of index DEPTH-1 accepted: transition to DONE in the same edge; that last write still issues (wea=1 for one cycle); done=1 from the following cycle. wr_ptr never wraps past DEPTH-1.
- DONE: done=1, wea=0, en=0, wr_count=DEPTH; prod_valid ignored (no RAM overwrite). start_stop=0 -> IDLE, done clears the cycle after; wr_count holds its value until the next run starts.
- Abort: start_stop=0 while in RUN -> IDLE; a product sampled valid on that same edge is dropped (no write); wea=0 next cycle; done stays 0; wr_count holds the partial count.
- start_stop held high across DONE: no new run; a new run requires start_stop low for >=1 cycle then high.
- Reset mid-run: the write pending at that edge is cancelled; wea=0 the cycle after rst sampled.
- Widths: addra = wr_ptr[ADDR_W-1:0]; wr_count saturates at DEPTH.

Optional Feature:
Macro RESULT_CHECKSUM_EN. When defined: adds output checksum [DATA_W-1:0], cleared on rst and on IDLE->RUN, XOR-accumulates every prod actually written (same edge as the write is registered); stable in DONE. When undefined: no checksum port, no extra logic; all other behaviour identical.

Test Plan:
- Reset: rst=1 two cycles with start_stop=1, prod_valid=1 -> en=0, wea=0, addra=0, dina=0, done=0, wr_count=0 throughout.
- Full run: start_stop=1, six back-to-back valids prod=0x00000001..0x00000006 -> wea high six consecutive cycles, addra 0..5, dina 1..6, done=1 the cycle after last write, wr_count=6.
- Gaps: valids on alternate cycles with prod=0xDEAD0000+i -> writes only on cycles following a valid, addra contiguous 0..5, no duplicates.
- Overflow guard: in DONE drive prod_valid=1, prod=0xFFFFFFFF for 4 cycles -> wea stays 0, addra stays 5; drop start_stop -> done=0 next cycle.
- Abort: after 3 writes drop start_stop with prod_valid=1 -> no 4th write, wr_count=3, done=0; restart -> first write at addra=0.
- Checksum (RESULT_CHECKSUM_EN): products 0x0F0F0F0F, 0xF0F0F0F0, 0x12345678, 0, 0, 0x12345678 -> checksum=0xFFFFFFFF in DONE.
